// File: rtl/multicycle_controller_pkg.sv
// Shared types for the multicycle controller: FSM state encoding, opcodes
// and instruction field positions.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC1,
        ST_EXEC2,
        ST_EXEC3,
        ST_DONE,
        ST_HALTED
    } state_e;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b100;
    localparam logic [2:0] OP_NOP  = 3'b101;

    function automatic int opc_msb(input int inst_w);
        return inst_w - 1;
    endfunction

    function automatic int rx_msb(input int inst_w, input int opc_w);
        return inst_w - opc_w - 1;
    endfunction

    function automatic int ry_msb(input int inst_w, input int opc_w, input int reg_w);
        return inst_w - opc_w - reg_w - 1;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction/handshake bundle between the external datapath and the controller.
interface multicycle_controller_if #(
    parameter int INST_W = 23,
    parameter int NREG   = 8
);
    logic              start;
    logic              run;
    logic [INST_W-1:0] inst;
    logic              alu_busy;
    logic [NREG+1:0]   r_en_oh;
    logic [NREG+1:0]   tri_oh;
    logic              alu_op;
    logic              ir_load;
    logic              inc_pc;
    logic              busy;
    logic              done;
    logic              halted;
    logic              illegal;

    modport master (
        output start, run, inst, alu_busy,
        input  r_en_oh, tri_oh, alu_op, ir_load, inc_pc, busy, done, halted, illegal
    );

    modport slave (
        input  start, run, inst, alu_busy,
        output r_en_oh, tri_oh, alu_op, ir_load, inc_pc, busy, done, halted, illegal
    );
endinterface

// File: rtl/multicycle_controller_onehot_decoder.sv
// Binary index to one-hot vector; out-of-range indices or en=0 give all-zero.
module onehot_decoder #(
    parameter int WIDTH_IN  = 4,
    parameter int WIDTH_OUT = 10
) (
    input  logic [WIDTH_IN-1:0]  bin,
    input  logic                 en,
    output logic [WIDTH_OUT-1:0] oh
);
    always_comb begin
        oh = '0;
        for (int i = 0; i < WIDTH_OUT; i++) begin
            if (en && bin == WIDTH_IN'(i)) oh[i] = 1'b1;
        end
    end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle datapath sequencer: fetch/decode/execute of MV, MVI, ADD, SUB,
// HALT and NOP, producing one-hot register load and bus driver selects.
//
// state     | meaning
// ST_IDLE   | waiting for start
// ST_FETCH  | load IR, advance PC
// ST_DECODE | classify opcode and register fields
// ST_EXEC1  | MV/MVI transfer, or ALU operand A latch
// ST_EXEC2  | ALU operand B, result into G; holds while alu_busy
// ST_EXEC3  | G written back to rx
// ST_DONE   | one-cycle completion, illegal flagged here
// ST_HALTED | parked until reset
module multicycle_controller #(
    parameter int INST_W = 23,
    parameter int OPC_W  = 3,
    parameter int REG_W  = 4,
    parameter int NREG   = 8
) (
    input logic                    clk,
    input logic                    rst,
    multicycle_controller_if.slave bus
);
    import ctrl_pkg::*;

    // One extra bit so NREG and NREG+1 (A and G) are always representable.
    localparam int SEL_W   = REG_W + 1;
    localparam int OPC_MSB = opc_msb(INST_W);
    localparam int RX_MSB  = rx_msb(INST_W, OPC_W);
    localparam int RY_MSB  = ry_msb(INST_W, OPC_W, REG_W);

    logic [OPC_W-1:0] opc;
    logic [REG_W-1:0] rx;
    logic [REG_W-1:0] ry;

    assign opc = bus.inst[OPC_MSB -: OPC_W];
    assign rx  = bus.inst[RX_MSB -: REG_W];
    assign ry  = bus.inst[RY_MSB -: REG_W];

    generate
        if (RY_MSB - REG_W >= 0) begin : g_spare
            logic unused_inst;
            assign unused_inst = ^bus.inst[RY_MSB-REG_W:0];
        end
    endgenerate

    logic is_mv, is_mvi, is_add, is_sub, is_halt, is_nop, is_arith, inst_bad;

    always_comb begin
        is_mv    = (opc == OPC_W'(OP_MV));
        is_mvi   = (opc == OPC_W'(OP_MVI));
        is_add   = (opc == OPC_W'(OP_ADD));
        is_sub   = (opc == OPC_W'(OP_SUB));
        is_halt  = (opc == OPC_W'(OP_HALT));
        is_nop   = (opc == OPC_W'(OP_NOP));
        is_arith = is_add | is_sub;
        inst_bad = !(is_mv | is_mvi | is_arith | is_halt | is_nop)
                 || ((is_mv | is_mvi | is_arith) && int'(rx) >= NREG)
                 || ((is_mv | is_arith) && int'(ry) >= NREG);
    end

    state_e           state_q, state_d;
    logic [SEL_W-1:0] r_sel_q, r_sel_d, t_sel_q, t_sel_d;
    logic             r_vld_q, r_vld_d, t_vld_q, t_vld_d;
    logic             alu_op_q, alu_op_d;
    logic             ir_load_q, ir_load_d;
    logic             inc_pc_q, inc_pc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             halted_q, halted_d;
    logic             illegal_q, illegal_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.start) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                if (inst_bad || is_nop) state_d = ST_DONE;
                else if (is_halt)       state_d = ST_HALTED;
                else                    state_d = ST_EXEC1;
            end
            ST_EXEC1:  state_d = is_arith ? ST_EXEC2 : ST_DONE;
            ST_EXEC2:  if (!bus.alu_busy) state_d = ST_EXEC3;
            ST_EXEC3:  state_d = ST_DONE;
            ST_DONE:   state_d = bus.run ? ST_FETCH : ST_IDLE;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        r_sel_d   = '0;
        t_sel_d   = '0;
        r_vld_d   = 1'b0;
        t_vld_d   = 1'b0;
        alu_op_d  = 1'b0;
        ir_load_d = 1'b0;
        inc_pc_d  = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        busy_d    = !(state_d == ST_IDLE || state_d == ST_HALTED);
        halted_d  = (state_d == ST_HALTED);
        case (state_d)
            ST_FETCH: begin
                ir_load_d = 1'b1;
                inc_pc_d  = 1'b1;
            end
            ST_EXEC1: begin
                r_vld_d = 1'b1;
                t_vld_d = 1'b1;
                r_sel_d = is_arith ? SEL_W'(NREG) : SEL_W'(rx);
                t_sel_d = is_mv ? SEL_W'(ry) : (is_mvi ? SEL_W'(NREG) : SEL_W'(rx));
            end
            ST_EXEC2: begin
                r_vld_d  = 1'b1;
                t_vld_d  = 1'b1;
                r_sel_d  = SEL_W'(NREG + 1);
                t_sel_d  = SEL_W'(ry);
                alu_op_d = is_sub;
            end
            ST_EXEC3: begin
                r_vld_d = 1'b1;
                t_vld_d = 1'b1;
                r_sel_d = SEL_W'(rx);
                t_sel_d = SEL_W'(NREG + 1);
            end
            ST_DONE: begin
                done_d    = 1'b1;
                illegal_d = inst_bad;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            r_sel_q   <= '0;
            t_sel_q   <= '0;
            r_vld_q   <= 1'b0;
            t_vld_q   <= 1'b0;
            alu_op_q  <= 1'b0;
            ir_load_q <= 1'b0;
            inc_pc_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_sel_q   <= r_sel_d;
            t_sel_q   <= t_sel_d;
            r_vld_q   <= r_vld_d;
            t_vld_q   <= t_vld_d;
            alu_op_q  <= alu_op_d;
            ir_load_q <= ir_load_d;
            inc_pc_q  <= inc_pc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    // G must not load while the ALU result is not yet valid.
    logic r_gate;
    assign r_gate = r_vld_q && !(state_q == ST_EXEC2 && bus.alu_busy);

    logic [NREG+1:0] r_oh, t_oh;

    onehot_decoder #(.WIDTH_IN(SEL_W), .WIDTH_OUT(NREG + 2)) u_r_dec (
        .bin (r_sel_q),
        .en  (r_gate),
        .oh  (r_oh)
    );

    onehot_decoder #(.WIDTH_IN(SEL_W), .WIDTH_OUT(NREG + 2)) u_t_dec (
        .bin (t_sel_q),
        .en  (t_vld_q),
        .oh  (t_oh)
    );

    assign bus.r_en_oh = r_oh;
    assign bus.tri_oh  = t_oh;
    assign bus.alu_op  = alu_op_q;
    assign bus.ir_load = ir_load_q;
    assign bus.inc_pc  = inc_pc_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.halted  = halted_q;
    assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller with hand-computed expectations.
module tb_multicycle_controller;

    logic clk;
    logic rst;
    int   nvec = 0;
    int   nerr = 0;
    int   lat;

    multicycle_controller_if #(.INST_W(23), .NREG(8)) bus ();

    multicycle_controller #(.INST_W(23), .OPC_W(3), .REG_W(4), .NREG(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ir_load, inc_pc, busy, done, halted, illegal, alu_op}
    function automatic logic [31:0] stat();
        return {25'd0, bus.ir_load, bus.inc_pc, bus.busy, bus.done,
                bus.halted, bus.illegal, bus.alu_op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] st,
                           input logic [31:0] ren, input logic [31:0] tri_v);
        chk({tag, ".stat"}, stat(), st);
        chk({tag, ".ren"}, {22'd0, bus.r_en_oh}, ren);
        chk({tag, ".tri"}, {22'd0, bus.tri_oh}, tri_v);
    endtask

    // Advance one clock; alu_busy applies to the cycle just entered.
    task automatic cyc(input logic b);
        @(posedge clk);
        #1;
        bus.alu_busy = b;
        #1;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (n < max) begin
            cyc(1'b0);
            bus.start = 1'b0;
            n++;
            if (bus.done) break;
        end
    endtask

    function automatic logic [22:0] mk(input logic [2:0] op, input logic [3:0] x,
                                       input logic [3:0] y);
        return {op, x, y, 12'h000};
    endfunction

    initial begin
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.run      = 1'b0;
        bus.inst     = '0;
        bus.alu_busy = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        chk_all("reset", 32'h00, 32'h000, 32'h000);
        rst = 1'b1;
        cyc(1'b0);
        chk_all("post_reset", 32'h00, 32'h000, 32'h000);

        // MV R3 <- R5, single step
        bus.inst  = mk(3'b000, 4'd3, 4'd5);
        bus.start = 1'b1;
        cyc(1'b0);
        bus.start = 1'b0;
        chk_all("mv.fetch", 32'h70, 32'h000, 32'h000);
        cyc(1'b0);
        chk_all("mv.decode", 32'h10, 32'h000, 32'h000);
        cyc(1'b0);
        chk_all("mv.exec1", 32'h10, 32'h008, 32'h020);
        cyc(1'b0);
        chk_all("mv.done", 32'h18, 32'h000, 32'h000);
        cyc(1'b0);
        chk_all("mv.idle", 32'h00, 32'h000, 32'h000);

        // SUB R1,R2 with three stall cycles in EXEC2
        bus.inst  = mk(3'b011, 4'd1, 4'd2);
        bus.start = 1'b1;
        cyc(1'b0);
        bus.start = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        chk_all("sub.exec1", 32'h10, 32'h100, 32'h002);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1);
            chk_all("sub.stall", 32'h11, 32'h000, 32'h004);
        end
        cyc(1'b0);
        chk_all("sub.release", 32'h11, 32'h200, 32'h004);
        cyc(1'b0);
        chk_all("sub.exec3", 32'h10, 32'h002, 32'h200);
        cyc(1'b0);
        chk_all("sub.done9", 32'h18, 32'h000, 32'h000);
        cyc(1'b0);
        chk_all("sub.idle", 32'h00, 32'h000, 32'h000);

        // Free-run MVI R7 then HALT
        bus.run   = 1'b1;
        bus.inst  = mk(3'b001, 4'd7, 4'd0);
        bus.start = 1'b1;
        cyc(1'b0);
        bus.start = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        chk_all("mvi.exec1", 32'h10, 32'h080, 32'h100);
        cyc(1'b0);
        chk_all("mvi.done", 32'h18, 32'h000, 32'h000);
        cyc(1'b0);
        chk_all("run.refetch", 32'h70, 32'h000, 32'h000);
        bus.inst = mk(3'b100, 4'd0, 4'd0);
        cyc(1'b0);
        chk_all("halt.decode", 32'h10, 32'h000, 32'h000);
        cyc(1'b0);
        chk_all("halted", 32'h04, 32'h000, 32'h000);
        bus.start = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        bus.start = 1'b0;
        chk_all("halted.start_ignored", 32'h04, 32'h000, 32'h000);
        rst = 1'b0;
        cyc(1'b0);
        chk_all("halted.reset", 32'h00, 32'h000, 32'h000);
        rst     = 1'b1;
        bus.run = 1'b0;
        cyc(1'b0);
        chk_all("halted.reset_after", 32'h00, 32'h000, 32'h000);

        // NOP whose unused register fields are out of range is still legal
        bus.inst  = mk(3'b101, 4'hF, 4'hF);
        bus.start = 1'b1;
        wait_done(20, lat);
        chk("nop.latency", lat, 3);
        chk_all("nop.done", 32'h18, 32'h000, 32'h000);

        // Illegal opcode 111
        cyc(1'b0);
        bus.inst  = mk(3'b111, 4'd1, 4'd1);
        bus.start = 1'b1;
        wait_done(20, lat);
        chk("ill_op.latency", lat, 3);
        chk_all("ill_op.done", 32'h1A, 32'h000, 32'h000);
        cyc(1'b0);
        chk_all("ill_op.idle", 32'h00, 32'h000, 32'h000);

        // MV with rx=9 beyond NREG
        bus.inst  = mk(3'b000, 4'd9, 4'd1);
        bus.start = 1'b1;
        wait_done(20, lat);
        chk("ill_rx.latency", lat, 3);
        chk_all("ill_rx.done", 32'h1A, 32'h000, 32'h000);

        // ADD with ry=8, one past the last register
        cyc(1'b0);
        bus.inst  = mk(3'b010, 4'd0, 4'd8);
        bus.start = 1'b1;
        wait_done(20, lat);
        chk_all("ill_ry.done", 32'h1A, 32'h000, 32'h000);
        cyc(1'b0);

        // Reset mid-stall in EXEC2 of ADD R2,R4
        bus.inst  = mk(3'b010, 4'd2, 4'd4);
        bus.start = 1'b1;
        cyc(1'b0);
        bus.start = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
        chk_all("add.stall", 32'h10, 32'h000, 32'h010);
        rst = 1'b0;
        cyc(1'b1);
        chk_all("add.reset", 32'h00, 32'h000, 32'h000);
        rst = 1'b1;
        cyc(1'b0);
        chk_all("add.reset_after", 32'h00, 32'h000, 32'h000);

        // Normal ADD after reset
        bus.start = 1'b1;
        wait_done(20, lat);
        chk("add.latency", lat, 6);
        chk_all("add.done", 32'h18, 32'h000, 32'h000);
        cyc(1'b0);
        chk_all("add.idle", 32'h00, 32'h000, 32'h000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter INST_W, default 23, instruction width.
REQ-002 Parameter OPC_W, default 3, opcode width; opcode = inst[INST_W-1 -: OPC_W].
REQ-003 Parameter REG_W, default 4, register-index field width; rx = inst[INST_W-OPC_W-1 -: REG_W], ry = next REG_W bits below rx.
REQ-004 Parameter NREG, default 8, general registers R0..R(NREG-1); NREG <= 2**REG_W.
REQ-005 The block SHALL have exactly one clock; reset is synchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous, active-low reset.
REQ-008 start  input  1  begin execution; sampled only in IDLE.
REQ-009 run  input  1  1 = free-run (fetch next after DONE), 0 = single-step (return to IDLE).
REQ-010 inst  input  INST_W  current instruction from external IR, stable from DECODE to DONE.
REQ-011 alu_busy  input  1  ALU not ready; stalls EXEC2.
REQ-012 r_en_oh  output  NREG+2  one-hot register load enable; bit NREG = A latch, bit NREG+1 = G latch.
REQ-013 tri_oh  output  NREG+2  one-hot bus driver select; bit NREG = immediate, bit NREG+1 = G.
REQ-014 alu_op  output  1  0 = add, 1 = sub; valid in EXEC2.
REQ-015 ir_load, inc_pc  output  1 each  load IR / advance PC; asserted in FETCH only.
REQ-016 busy, done, halted, illegal  output  1 each  status flags.

Function
REQ-017 States: IDLE, FETCH, DECODE, EXEC1, EXEC2, EXEC3, DONE, HALTED.
REQ-018 IDLE: start=1 -> FETCH; otherwise stay. FETCH -> DECODE unconditionally.
REQ-019 DECODE opcodes: 000 MV, 001 MVI, 010 ADD, 011 SUB, 100 HALT, 101 NOP; 110/111 illegal.
REQ-020 MV: EXEC1 drives tri_oh[ry], r_en_oh[rx] -> DONE.
REQ-021 MVI: EXEC1 drives tri_oh[NREG], r_en_oh[rx] -> DONE.
REQ-022 ADD/SUB: EXEC1 tri_oh[rx], r_en_oh[NREG]; EXEC2 tri_oh[ry], r_en_oh[NREG+1], alu_op; EXEC3 tri_oh[NREG+1], r_en_oh[rx] -> DONE.
REQ-023 EXEC2 with alu_busy=1 SHALL remain in EXEC2 with r_en_oh forced to zero and tri_oh/alu_op held; advances on first cycle alu_busy=0.
REQ-024 NOP: DECODE -> DONE. HALT: DECODE -> HALTED; HALTED persists until reset, halted=1, start ignored.
REQ-025 Illegal opcode, or rx/ry >= NREG for an opcode that uses it: DECODE -> DONE, illegal=1 during that DONE cycle, no r_en_oh/tri_oh bit asserted.
REQ-026 DONE: done=1 for exactly one cycle; run=1 -> FETCH, run=0 -> IDLE.
REQ-027 r_en_oh and tri_oh SHALL each have at most one bit set every cycle; all-zero in IDLE, FETCH, DECODE, DONE, HALTED.
REQ-028 busy=1 in every state except IDLE and HALTED.
REQ-029 start asserted while busy or halted SHALL have no effect.
REQ-030 Latency from start sampled in IDLE to done: MV/MVI 4 cycles, ADD/SUB 6 cycles plus stall cycles, NOP 3 cycles.
REQ-031 All outputs SHALL be decoded from the registered state and inst only (Moore/registered-state; no combinational path from start or run to outputs).

Reset
REQ-032 rst=0 at a rising edge SHALL force IDLE regardless of state, including mid-instruction, EXEC2 stall, and HALTED.
REQ-033 While in reset and the cycle after: all outputs 0, r_en_oh/tri_oh all-zero.

Structure
REQ-034 State enum, opcode constants and field-position helpers SHALL live in shared package ctrl_pkg.
REQ-035 Binary-to-one-hot conversion SHALL use one parametrised sub-module, onehot_decoder (WIDTH_IN, WIDTH_OUT), instantiated for r_en_oh and tri_oh.

Verification
REQ-036 MV R3<-R5 (inst[22:12]=000_0011_0101), run=0, start pulse -> FETCH ir_load/inc_pc, EXEC1 tri_oh=0x020 r_en_oh=0x008, done 4 cycles after start, then IDLE.
REQ-037 SUB R1,R2 with alu_busy=1 for 3 cycles in EXEC2 -> r_en_oh=0 during stall, alu_op=1, G latched (r_en_oh=0x200) on release, R1 written (r_en_oh=0x002) in EXEC3, done at cycle 9.
REQ-038 run=1, MVI then HALT -> done once, FETCH again, HALTED reached, halted=1, busy=0, later start ignored.
REQ-039 Opcode 111 and MV with rx=9 (NREG=8) -> illegal=1 with done, no enable bits set, returns to IDLE.
REQ-040 rst=0 during EXEC2 of ADD and during HALTED -> next cycle IDLE, all outputs zero; start afterwards resumes normally.
